// File: rtl/hd_decode.sv
// Huffman header decoder: rebuilds the pre-order tree from SPI bytes into per-character
// code records written to SRAM, then captures the 32-bit total character count.
module hd_decode (
  input  logic         clk,
  input  logic         rst,
  input  logic         hd_enable,
  input  logic [7:0]   SPI_data_in,
  output logic         SPI_read_en,
  output logic [127:0] SRAM_data_out,
  output logic         SRAM_write_en,
  output logic [31:0]  tot_chars,
  output logic         finished
);

  typedef enum logic [2:0] {
    INIT,
    READ_LEADING_BIT,
    READ_CHAR,
    WRITE_PATH,
    UPDATE_PATH,
    READ_TOT_CHAR,
    FINISH
  } state_t;

  state_t state, state_nxt;

  logic [7:0]   bit_buf;
  logic [3:0]   bit_cnt;
  logic         wait_cap;
  logic [111:0] path;
  logic [7:0]   len;
  logic [7:0]   char_r;
  logic [2:0]   char_cnt;
  logic [2:0]   byte_cnt;

  logic         wants_bit;
  logic         bit_ok;
  logic         cur_bit;
  logic         fetch_go;
  logic [7:0]   trail_ones;
  logic         trail_run;
  logic [111:0] stripped_path;
  logic [7:0]   stripped_len;

  assign wants_bit = (state == READ_LEADING_BIT) || (state == READ_CHAR);
  assign bit_ok    = wants_bit && (bit_cnt != 4'd0);
  assign cur_bit   = bit_buf[7];
  assign finished  = (state == FINISH);

  // A request is only raised once the previous byte has been captured.
  assign fetch_go = hd_enable && !SPI_read_en && !wait_cap &&
                    ((wants_bit && (bit_cnt == 4'd0)) || (state == READ_TOT_CHAR));

  // Bits above len are always zero, so the trailing-ones run stops at len by itself.
  always_comb begin
    trail_ones = 8'd0;
    trail_run  = 1'b1;
    for (int i = 0; i < 112; i++) begin
      if (trail_run && path[i]) trail_ones = trail_ones + 8'd1;
      else                      trail_run  = 1'b0;
    end
    stripped_path = path >> trail_ones;
    stripped_len  = len - trail_ones;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!hd_enable) begin
      state_nxt = INIT;
    end else begin
      case (state)
        INIT:             state_nxt = READ_LEADING_BIT;
        READ_LEADING_BIT: if (bit_ok && cur_bit) state_nxt = READ_CHAR;
        READ_CHAR:        if (bit_ok && (char_cnt == 3'd7)) state_nxt = WRITE_PATH;
        WRITE_PATH:       state_nxt = UPDATE_PATH;
        UPDATE_PATH:      state_nxt = (stripped_len == 8'd0) ? READ_TOT_CHAR : READ_LEADING_BIT;
        READ_TOT_CHAR:    if (wait_cap && (byte_cnt == 3'd3)) state_nxt = FINISH;
        FINISH:           state_nxt = FINISH;
        default:          state_nxt = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_buf       <= 8'd0;
      bit_cnt       <= 4'd0;
      wait_cap      <= 1'b0;
      SPI_read_en   <= 1'b0;
      path          <= 112'd0;
      len           <= 8'd0;
      char_r        <= 8'd0;
      char_cnt      <= 3'd0;
      byte_cnt      <= 3'd0;
      tot_chars     <= 32'd0;
      SRAM_write_en <= 1'b0;
      SRAM_data_out <= 128'd0;
    end else if (!hd_enable || (state == INIT)) begin
      bit_buf       <= 8'd0;
      bit_cnt       <= 4'd0;
      wait_cap      <= 1'b0;
      SPI_read_en   <= 1'b0;
      path          <= 112'd0;
      len           <= 8'd0;
      char_r        <= 8'd0;
      char_cnt      <= 3'd0;
      byte_cnt      <= 3'd0;
      tot_chars     <= 32'd0;
      SRAM_write_en <= 1'b0;
    end else begin
      SRAM_write_en <= 1'b0;
      SPI_read_en   <= fetch_go;
      wait_cap      <= SPI_read_en;

      if (wait_cap && (state != READ_TOT_CHAR)) begin
        bit_buf <= SPI_data_in;
        bit_cnt <= 4'd8;
      end else if (bit_ok) begin
        bit_buf <= {bit_buf[6:0], 1'b0};
        bit_cnt <= bit_cnt - 4'd1;
      end

      if (wait_cap && (state == READ_TOT_CHAR)) begin
        tot_chars <= {tot_chars[23:0], SPI_data_in};
        byte_cnt  <= byte_cnt + 3'd1;
      end

      case (state)
        READ_LEADING_BIT: begin
          // Depth beyond the path width saturates; extra pushes are dropped.
          if (bit_ok && !cur_bit && (len < 8'd112)) begin
            path <= {path[110:0], 1'b0};
            len  <= len + 8'd1;
          end
        end
        READ_CHAR: begin
          if (bit_ok) begin
            char_r   <= {char_r[6:0], cur_bit};
            char_cnt <= char_cnt + 3'd1;
          end
        end
        WRITE_PATH: begin
          SRAM_data_out <= {char_r, len, path};
          SRAM_write_en <= 1'b1;
        end
        UPDATE_PATH: begin
          len <= stripped_len;
          if (stripped_len == 8'd0) begin
            path    <= stripped_path;
            bit_buf <= 8'd0;
            bit_cnt <= 4'd0;
          end else begin
            path <= stripped_path | 112'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hd_decode.sv
// Bench for hd_decode: directed and random trees checked against a pre-order tree model.
module tb_hd_decode;

  logic         clk = 1'b0;
  logic         rst;
  logic         hd_enable;
  logic [7:0]   SPI_data_in;
  logic         SPI_read_en;
  logic [127:0] SRAM_data_out;
  logic         SRAM_write_en;
  logic [31:0]  tot_chars;
  logic         finished;

  hd_decode dut (
    .clk(clk), .rst(rst), .hd_enable(hd_enable),
    .SPI_data_in(SPI_data_in), .SPI_read_en(SPI_read_en),
    .SRAM_data_out(SRAM_data_out), .SRAM_write_en(SRAM_write_en),
    .tot_chars(tot_chars), .finished(finished)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit           tree_bits[$];
  bit           code_q[$];
  bit           tree_done;
  logic [127:0] exp_rec[$];
  logic [7:0]   spi_q[$];
  bit           stall_mode;

  logic [127:0] got_rec[$];
  int           cyc = 0;
  int           last_req;
  bit           had_req;
  int           fin_cyc;
  bit           fin_seen;
  int           viol = 0;
  bit           prev_wr;
  int           spi_idx;
  bit           hold;

  always @(posedge clk) cyc <= cyc + 1;

  // SPI responder and output monitor. The byte is presented during the request cycle
  // and held through the following capture edge; in stall mode the bus carries junk otherwise.
  always @(negedge clk) begin
    if (rst || !hd_enable) begin
      got_rec.delete();
      had_req     = 0;
      fin_seen    = 0;
      prev_wr     = 0;
      spi_idx     = 0;
      hold        = 0;
      SPI_data_in = 8'd0;
    end else begin
      if (SRAM_write_en) begin
        got_rec.push_back(SRAM_data_out);
        if (prev_wr) viol++;
      end
      prev_wr = SRAM_write_en;
      if (SPI_read_en) begin
        if (had_req && (cyc - last_req) < 2) viol++;
        had_req  = 1;
        last_req = cyc;
      end
      if (finished && !fin_seen) begin
        fin_seen = 1;
        fin_cyc  = cyc;
      end
      if (SPI_read_en) begin
        SPI_data_in = (spi_idx < spi_q.size()) ? spi_q[spi_idx] : 8'hEE;
        spi_idx++;
        hold = 1;
      end else if (hold) begin
        hold = 0;
      end else if (stall_mode) begin
        SPI_data_in = 8'($urandom);
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic begin_tree();
    tree_bits.delete();
    code_q.delete();
    exp_rec.delete();
    tree_done = 0;
  endtask

  task automatic m_internal();
    tree_bits.push_back(1'b0);
    code_q.push_back(1'b0);
  endtask

  // Leaf: emit its record, then climb to the next unvisited right branch.
  task automatic m_leaf(input logic [7:0] c);
    logic [111:0] p;
    tree_bits.push_back(1'b1);
    for (int i = 7; i >= 0; i--) tree_bits.push_back(c[i]);
    p = '0;
    foreach (code_q[i]) p = {p[110:0], code_q[i]};
    exp_rec.push_back({c, 8'(code_q.size()), p});
    while (code_q.size() > 0 && code_q[code_q.size()-1] == 1'b1) void'(code_q.pop_back());
    if (code_q.size() == 0) tree_done = 1;
    else code_q[code_q.size()-1] = 1'b1;
  endtask

  task automatic end_tree(input logic [31:0] cnt);
    while (tree_bits.size() % 8 != 0) tree_bits.push_back(1'b0);
    spi_q.delete();
    for (int i = 0; i < tree_bits.size(); i += 8) begin
      logic [7:0] b;
      b = '0;
      for (int j = 0; j < 8; j++) b = {b[6:0], tree_bits[i+j]};
      spi_q.push_back(b);
    end
    spi_q.push_back(cnt[31:24]);
    spi_q.push_back(cnt[23:16]);
    spi_q.push_back(cnt[15:8]);
    spi_q.push_back(cnt[7:0]);
  endtask

  task automatic rand_tree(input logic [31:0] cnt);
    int nodes;
    nodes = 0;
    begin_tree();
    while (!tree_done) begin
      if (code_q.size() < 6 && nodes < 16 && $urandom_range(0, 1) == 1) m_internal();
      else m_leaf(8'($urandom_range(0, 255)));
      nodes++;
    end
    end_tree(cnt);
  endtask

  task automatic load_two_leaf();
    spi_q   = '{8'h50, 8'h68, 8'h40, 8'h00, 8'h00, 8'h00, 8'h03};
    exp_rec = '{{8'h41, 8'd1, 112'd0}, {8'h42, 8'd1, 112'd1}};
  endtask

  task automatic run_tree(input string tag, input logic [31:0] cnt, input bit stall);
    int k;
    stall_mode = stall;
    hd_enable  = 1'b1;
    k = 0;
    while (!finished && k < 20000) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk({tag, "_finished"}, 128'(finished), 128'd1);
    chk({tag, "_nrec"}, 128'(got_rec.size()), 128'(exp_rec.size()));
    for (int i = 0; i < exp_rec.size() && i < got_rec.size(); i++)
      chk($sformatf("%s_rec%0d", tag, i), got_rec[i], exp_rec[i]);
    chk({tag, "_tot"}, 128'(tot_chars), 128'(cnt));
    chk({tag, "_fin_lat"}, 128'(fin_cyc - last_req), 128'd2);
    chk({tag, "_proto"}, 128'(viol), 128'd0);
    hd_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_drop"}, 128'(finished), 128'd0);
    stall_mode = 0;
  endtask

  initial begin
    int k;
    int idle_bad;
    rst = 1'b1;
    hd_enable = 1'b0;
    stall_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_read_en", 128'(SPI_read_en), 128'd0);
    chk("rst_write_en", 128'(SRAM_write_en), 128'd0);
    chk("rst_data", SRAM_data_out, 128'd0);
    chk("rst_tot", 128'(tot_chars), 128'd0);
    chk("rst_finished", 128'(finished), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    load_two_leaf();
    run_tree("two_leaf", 32'd3, 0);

    spi_q   = '{8'hA0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h05};
    exp_rec = '{{8'h41, 8'd0, 112'd0}};
    run_tree("root_leaf", 32'd5, 0);

    begin_tree();
    m_internal(); m_internal();
    m_leaf(8'h41); m_leaf(8'h42); m_leaf(8'h43);
    end_tree(32'd10);
    run_tree("three_leaf", 32'd10, 0);

    load_two_leaf();
    run_tree("stall", 32'd3, 1);

    for (int t = 0; t < 8; t++) begin
      logic [31:0] cnt;
      cnt = $urandom;
      rand_tree(cnt);
      run_tree($sformatf("rand%0d", t), cnt, t[0]);
    end

    // Reset in the middle of the second character.
    load_two_leaf();
    hd_enable = 1'b1;
    k = 0;
    while (!SRAM_write_en && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("mid_wait", 128'(SRAM_write_en), 128'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_read_en", 128'(SPI_read_en), 128'd0);
    chk("mid_write_en", 128'(SRAM_write_en), 128'd0);
    chk("mid_data", SRAM_data_out, 128'd0);
    chk("mid_tot", 128'(tot_chars), 128'd0);
    chk("mid_finished", 128'(finished), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    run_tree("restart", 32'd3, 0);

    hd_enable = 1'b0;
    idle_bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (SPI_read_en || SRAM_write_en) idle_bad++;
    end
    chk("idle_strobes", 128'(idle_bad), 128'd0);
    chk("idle_finished", 128'(finished), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
